// File: rtl/logicnet_pkg.sv
// Shared constants and types for the MNIST input packer.
// Default frame geometry, threshold and packer FSM states.
package logicnet_pkg;

   localparam int DEF_N_PIXELS = 784;
   localparam int DEF_PIX_W    = 8;
   localparam int DEF_THRESH   = 128;
   localparam int DEF_CNT_W    = 16;

   typedef enum logic [1:0] {
      FILL    = 2'd0,
      HOLD    = 2'd1,
      DISCARD = 2'd2
   } packer_state_t;

endpackage

// File: rtl/mnist_input_packer_if.sv
// Valid/ready stream bundle used for both the pixel input
// and the packed-frame output of the packer.
interface mnist_input_packer_if
   import logicnet_pkg::*;
#(
   parameter int W = DEF_PIX_W
) ();

   logic         valid;
   logic         ready;
   logic         last;
   logic [W-1:0] data;

   modport master (
      output valid,
      output data,
      output last,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      input  last,
      output ready
   );

endinterface

// File: rtl/logicnet_frame_reg.sv
// Output holding register for one packed frame.
// Holds data stable while valid and not yet accepted.
module logicnet_frame_reg
   import logicnet_pkg::*;
#(
   parameter int N_PIXELS = DEF_N_PIXELS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [N_PIXELS-1:0] load_data,
   input  logic                m_ready,
   output logic                m_valid,
   output logic [N_PIXELS-1:0] m_data
);

   // Load a new frame, or drop valid once the consumer takes it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
      end else if (load) begin
         m_valid <= 1'b1;
         m_data  <= load_data;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/mnist_input_packer.sv
// Binarises a serial pixel stream and packs each frame
// into one wide word for the layer-0 LUT neurons.
module mnist_input_packer
   import logicnet_pkg::*;
#(
   parameter int N_PIXELS = DEF_N_PIXELS,
   parameter int PIX_W    = DEF_PIX_W,
   parameter int THRESH   = DEF_THRESH,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   mnist_input_packer_if.slave  s,
   mnist_input_packer_if.master m,
   output logic [CNT_W-1:0]     frame_cnt,
   output logic                 err_len,
   input  logic                 err_clr
);

   localparam int IDX_W = $clog2(N_PIXELS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIXELS - 1);

   packer_state_t       state;
   packer_state_t       state_n;
   logic [IDX_W-1:0]    pix_idx;
   logic [IDX_W-1:0]    pix_idx_n;
   logic [N_PIXELS-1:0] build;
   logic [N_PIXELS-1:0] build_n;
   logic [N_PIXELS-1:0] load_data;
   logic                xfer;
   logic                pix_bit;
   logic                at_last;
   logic                load;
   logic                err_set;
   logic                hs;

   assign s.ready   = rst && (state != HOLD);
   assign xfer      = s.valid && s.ready;
   assign pix_bit   = (s.data >= PIX_W'(THRESH));
   assign at_last   = (pix_idx == LAST_IDX);
   assign hs        = m.valid && m.ready;
   assign m.last    = 1'b1;
   assign load_data = (state == HOLD) ? build : build_n;

   // Build vector with the incoming pixel bit merged in.
   always_comb begin
      build_n          = build;
      build_n[pix_idx] = pix_bit;
   end

   // Next-state, index and frame-complete decisions.
   always_comb begin
      state_n   = state;
      pix_idx_n = pix_idx;
      load      = 1'b0;
      err_set   = 1'b0;
      unique case (state)
         FILL: begin
            if (xfer) begin
               if (s.last && at_last) begin
                  pix_idx_n = '0;
                  if (!m.valid || m.ready) begin
                     load = 1'b1;
                  end else begin
                     state_n = HOLD;
                  end
               end else if (s.last) begin
                  pix_idx_n = '0;
                  err_set   = 1'b1;
               end else if (at_last) begin
                  pix_idx_n = '0;
                  err_set   = 1'b1;
                  state_n   = DISCARD;
               end else begin
                  pix_idx_n = pix_idx + 1'b1;
               end
            end
         end
         HOLD: begin
            if (m.ready) begin
               load    = 1'b1;
               state_n = FILL;
            end
         end
         DISCARD: begin
            if (xfer && s.last) begin
               pix_idx_n = '0;
               state_n   = FILL;
            end
         end
         default: begin
            state_n   = FILL;
            pix_idx_n = '0;
         end
      endcase
   end

   // FSM state and pixel index registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= FILL;
         pix_idx <= '0;
      end else begin
         state   <= state_n;
         pix_idx <= pix_idx_n;
      end
   end

   // Capture binarised pixels while filling a frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         build <= '0;
      end else if (xfer && (state == FILL)) begin
         build <= build_n;
      end
   end

   // Count delivered frames on each output handshake.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_cnt <= '0;
      end else if (hs) begin
         frame_cnt <= frame_cnt + 1'b1;
      end
   end

   // Sticky length error; a new error beats a clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_len <= 1'b0;
      end else if (err_set) begin
         err_len <= 1'b1;
      end else if (err_clr) begin
         err_len <= 1'b0;
      end
   end

   logicnet_frame_reg #(
      .N_PIXELS (N_PIXELS)
   ) u_frame_reg (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_data (load_data),
      .m_ready   (m.ready),
      .m_valid   (m.valid),
      .m_data    (m.data)
   );

endmodule
